// File: rtl/acc_pingpong_buf.sv
// Ping-pong accumulation buffer between the PE array and the PPU: sums K-step partial sums into a
// 16x16 tile per bank and drains a full bank as a start pulse followed by 16 rows. Optional macro: ACC_SAT_EN.
module acc_pingpong_buf #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned ROWS   = 16,
  parameter int unsigned PSUM_W = 20,
  parameter int unsigned ACC_W  = 24
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_psum_valid,
  output logic                       o_psum_ready,
  input  logic [LANES*PSUM_W-1:0]    i_psum_data,
  input  logic [$clog2(ROWS)-1:0]    i_psum_row,
  input  logic                       i_psum_first,
  input  logic                       i_psum_last,
  output logic                       o_ppu_start,
  output logic                       o_acc_valid,
  output logic [LANES*ACC_W-1:0]     o_acc_data,
  output logic                       o_busy,
  output logic                       o_sat
);

  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned ROW_BITS = LANES * ACC_W;
`ifdef ACC_SAT_EN
  localparam int unsigned SUM_W = ACC_W + 1;
`else
  localparam int unsigned SUM_W = ACC_W;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_STREAM
  } state_e;

  state_e               state_q, state_d;
  logic [ROW_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic [1:0]           full_q, full_d;
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic                 sat_q, sat_d;
  logic                 start_q, start_d;
  logic                 valid_q, valid_d;
  logic [ROW_BITS-1:0]  data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  // Storage: entry {bank,row} holds one full row of lane accumulators
  logic [ROW_BITS-1:0]  mem_q [2*ROWS];

  logic                 accept;
  logic                 tile_close;
  logic [ROW_BITS-1:0]  cur_row;
  logic [ROW_BITS-1:0]  wr_row_d;
  logic signed [PSUM_W-1:0] psum_g;
  logic signed [ACC_W-1:0]  acc_g;
  logic signed [SUM_W-1:0]  sum_g;
  logic [ACC_W-1:0]         res_g;
`ifdef ACC_SAT_EN
  logic [LANES-1:0]         ovf_c;
`endif

  assign accept     = i_psum_valid && ready_q;
  assign tile_close = accept && i_psum_last && (i_psum_row == ROW_W'(ROWS - 1));
  assign cur_row    = mem_q[{wr_bank_q, i_psum_row}];

  // Per-lane overwrite or accumulate of the addressed row
  always_comb begin
    wr_row_d = '0;
    psum_g   = '0;
    acc_g    = '0;
    sum_g    = '0;
    res_g    = '0;
`ifdef ACC_SAT_EN
    ovf_c    = '0;
`endif
    for (int g = 0; g < LANES; g++) begin
      psum_g = $signed(i_psum_data[g*PSUM_W +: PSUM_W]);
      acc_g  = $signed(cur_row[g*ACC_W +: ACC_W]);
      if (i_psum_first) sum_g = SUM_W'(psum_g);
      else              sum_g = SUM_W'(acc_g) + SUM_W'(psum_g);
`ifdef ACC_SAT_EN
      if (sum_g[SUM_W-1] != sum_g[SUM_W-2]) begin
        ovf_c[g] = 1'b1;
        res_g    = sum_g[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        res_g    = sum_g[ACC_W-1:0];
      end
`else
      res_g = sum_g;
`endif
      wr_row_d[g*ACC_W +: ACC_W] = res_g;
    end
  end

  // Bank bookkeeping, drain FSM and next values of the registered outputs
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;

    if (tile_close) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end

    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) state_d = S_START;
      end
      S_START: begin
        rd_cnt_d = '0;
        state_d  = S_STREAM;
      end
      S_STREAM: begin
        if (rd_cnt_q == ROW_W'(ROWS - 1)) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          rd_cnt_d          = '0;
          state_d           = S_IDLE;
        end else begin
          rd_cnt_d = ROW_W'(rd_cnt_q + 1'b1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of what the next state will present
    start_d = (state_d == S_START);
    valid_d = (state_d == S_STREAM);
    data_d  = valid_d ? mem_q[{rd_bank_d, rd_cnt_d}] : '0;
    ready_d = ~full_d[wr_bank_d];
    busy_d  = (|full_d) || (state_d != S_IDLE);
`ifdef ACC_SAT_EN
    sat_d   = sat_q || (accept && (|ovf_c));
`else
    sat_d   = 1'b0;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      rd_cnt_q  <= '0;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      sat_q     <= 1'b0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      sat_q     <= sat_d;
      start_q   <= start_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  // Accumulator contents need no reset; a tile is rebuilt by its first K-step
  always_ff @(posedge i_clk) begin
    if (accept) mem_q[{wr_bank_q, i_psum_row}] <= wr_row_d;
  end

  assign o_psum_ready = ready_q;
  assign o_ppu_start  = start_q;
  assign o_acc_valid  = valid_q;
  assign o_acc_data   = data_q;
  assign o_busy       = busy_q;
  assign o_sat        = sat_q;

endmodule
